mslope_meas_sequencer: RTL and testbench

//  Schedules the multi-slope converter through a ZERO -> INPUT [-> REF] measurement sequence.
//  Per phase: steers the front-end mux, fires conv_start, collects the per-conversion count bundle
//  and weights it into a signed charge value. Emits the auto-zeroed result (INPUT - ZERO) on a

---
 rtl/mslope_pkg.sv | 31 +++
 rtl/mslope_raw_calc.sv | 48 ++++
 rtl/mslope_meas_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mslope_meas_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mslope_pkg.sv
// Shared types and slope weights for the multi-slope measurement sequencer.
package mslope_pkg;

  typedef enum logic [1:0] {
    PH_ZERO,
    PH_INPUT,
    PH_REF
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_CALC,
    ST_OUT
  } state_e;

  localparam int unsigned W_RUNDOWN = 512;
  localparam int unsigned W_N64     = 64;
  localparam int unsigned W_P8      = 8;
  localparam int unsigned W_N1      = 1;

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_ZERO: return PH_INPUT;
      default: return PH_REF;
    endcase
  endfunction

endpackage

// File: rtl/mslope_raw_calc.sv
// Registered weighting of one conversion's count bundle into a signed charge value.
module mslope_raw_calc
  import mslope_pkg::*;
#(
  parameter int unsigned RUNUP_W = 250,
  parameter int unsigned RES_W   = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_capture,
  input  logic [31:0]             i_pwm_p,
  input  logic [31:0]             i_pwm_n,
  input  logic [11:0]             i_rundown,
  input  logic [7:0]              i_n64,
  input  logic [7:0]              i_p8,
  input  logic [7:0]              i_n1,
  output logic signed [RES_W-1:0] o_raw,
  output logic                    o_valid
);

  logic [RES_W-1:0]        w_runup;
  logic [RES_W-1:0]        w_slopes;
  logic signed [RES_W-1:0] r_raw;
  logic                    r_valid;

  // Counts are unsigned; the run-up difference carries the sign, all in modulo-2^RES_W arithmetic.
  always_comb begin
    w_runup  = (RES_W'(i_pwm_p) - RES_W'(i_pwm_n)) * RES_W'(RUNUP_W);
    w_slopes = RES_W'(i_rundown) * RES_W'(W_RUNDOWN)
             - RES_W'(i_n64) * RES_W'(W_N64)
             + RES_W'(i_p8) * RES_W'(W_P8)
             - RES_W'(i_n1) * RES_W'(W_N1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_raw   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_capture;
      if (i_capture) r_raw <= signed'(w_runup + w_slopes);
    end
  end

  assign o_raw   = r_raw;
  assign o_valid = r_valid;

endmodule

// File: rtl/mslope_meas_sequencer.sv
// Multi-slope ZERO -> INPUT [-> REF] measurement sequencer with auto-zeroed result handshake.
// Define REF_CAL_EN to add the REF calibration phase and drive sel_ref / ref_data.
module mslope_meas_sequencer
  import mslope_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned TIMEOUT_CYC = 400000,
  parameter int unsigned RUNUP_W     = 250,
  parameter int unsigned RES_W       = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic                    conv_start,
  input  logic                    conv_done,
  input  logic [31:0]             pwm_p,
  input  logic [31:0]             pwm_n,
  input  logic [11:0]             rundown,
  input  logic [7:0]              n64,
  input  logic [7:0]              p8,
  input  logic [7:0]              n1,
  output logic                    sel_zero,
  output logic                    sel_input,
  output logic                    sel_ref,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [RES_W-1:0] res_data,
  output logic signed [RES_W-1:0] ref_data,
  output logic                    err_timeout,
  output logic [7:0]              err_cnt
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
`ifdef REF_CAL_EN
  localparam phase_e LAST_PHASE = PH_REF;
`else
  localparam phase_e LAST_PHASE = PH_INPUT;
`endif

  state_e                  r_state, w_state_nx;
  phase_e                  r_phase, w_phase_nx;
  logic [SW-1:0]           r_settle;
  logic [TW-1:0]           r_tcnt;
  logic [7:0]              r_err_cnt;
  logic signed [RES_W-1:0] r_zero_raw, r_input_raw;
  logic signed [RES_W-1:0] w_raw;
  logic                    w_raw_valid, w_capture, w_timeout, w_active;

  assign w_capture = conv_done && (r_state == ST_WAIT);

  mslope_raw_calc #(
    .RUNUP_W (RUNUP_W),
    .RES_W   (RES_W)
  ) u_raw_calc (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_pwm_p   (pwm_p),
    .i_pwm_n   (pwm_n),
    .i_rundown (rundown),
    .i_n64     (n64),
    .i_p8      (p8),
    .i_n1      (n1),
    .o_raw     (w_raw),
    .o_valid   (w_raw_valid)
  );

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_phase_nx = PH_ZERO;
        if (enable) w_state_nx = ST_SETTLE;
      end
      ST_SETTLE: if (r_settle == SW'(SETTLE_CYC - 1)) w_state_nx = ST_START;
      ST_START:  w_state_nx = ST_WAIT;
      ST_WAIT: begin
        // conv_done takes priority over a timeout expiring in the same cycle
        if (conv_done) begin
          w_state_nx = ST_CALC;
        end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
          w_timeout  = 1'b1;
          w_state_nx = ST_IDLE;
          w_phase_nx = PH_ZERO;
        end
      end
      ST_CALC: begin
        if (!enable) begin
          w_state_nx = ST_IDLE;
          w_phase_nx = PH_ZERO;
        end else if (r_phase != LAST_PHASE) begin
          w_state_nx = ST_SETTLE;
          w_phase_nx = next_phase(r_phase);
        end else begin
          w_state_nx = ST_OUT;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          w_state_nx = enable ? ST_SETTLE : ST_IDLE;
          w_phase_nx = PH_ZERO;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_phase_nx = PH_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= PH_ZERO;
      r_settle    <= '0;
      r_tcnt      <= '0;
      r_err_cnt   <= '0;
      r_zero_raw  <= '0;
      r_input_raw <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_phase  <= w_phase_nx;
      r_settle <= (r_state == ST_SETTLE) ? r_settle + SW'(1) : '0;
      r_tcnt   <= (r_state == ST_WAIT) ? r_tcnt + TW'(1) : '0;
      if (w_timeout && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 8'd1;
      if ((r_state == ST_CALC) && w_raw_valid) begin
        if (r_phase == PH_ZERO)       r_zero_raw  <= w_raw;
        else if (r_phase == PH_INPUT) r_input_raw <= w_raw;
      end
    end
  end

  assign w_active    = (r_state != ST_IDLE);
  assign conv_start  = (r_state == ST_START);
  assign res_valid   = (r_state == ST_OUT);
  assign err_timeout = w_timeout;
  assign err_cnt     = r_err_cnt;
  assign sel_zero    = w_active && (r_phase == PH_ZERO);
  assign sel_input   = w_active && (r_phase == PH_INPUT);
  assign res_data    = r_input_raw - r_zero_raw;

`ifdef REF_CAL_EN
  logic signed [RES_W-1:0] r_ref_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                        r_ref_raw <= '0;
    else if ((r_state == ST_CALC) && w_raw_valid && (r_phase == PH_REF)) r_ref_raw <= w_raw;
  end

  assign sel_ref  = w_active && (r_phase == PH_REF);
  assign ref_data = r_ref_raw - r_zero_raw;
`else
  assign sel_ref  = 1'b0;
  assign ref_data = '0;
`endif

endmodule

// File: tb/tb_mslope_meas_sequencer.sv
// Self-checking bench for mslope_meas_sequencer; REF phase checks follow REF_CAL_EN.
module tb_mslope_meas_sequencer;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 100;
  localparam int unsigned RUNUP  = 250;
  localparam int unsigned RW     = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          conv_done = 1'b0;
  logic          res_ready = 1'b0;
  logic [31:0]   pwm_p = '0, pwm_n = '0;
  logic [11:0]   rundown = '0;
  logic [7:0]    n64 = '0, p8 = '0, n1 = '0;
  logic          conv_start, sel_zero, sel_input, sel_ref, res_valid, err_timeout;
  logic [RW-1:0] res_data, ref_data;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  typedef struct {
    logic [31:0] p;
    logic [31:0] n;
    logic [11:0] rd;
    logic [7:0]  n64;
    logic [7:0]  p8;
    logic [7:0]  n1;
  } bundle_t;

  mslope_meas_sequencer #(
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TMO),
    .RUNUP_W     (RUNUP),
    .RES_W       (RW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .conv_start  (conv_start),
    .conv_done   (conv_done),
    .pwm_p       (pwm_p),
    .pwm_n       (pwm_n),
    .rundown     (rundown),
    .n64         (n64),
    .p8          (p8),
    .n1          (n1),
    .sel_zero    (sel_zero),
    .sel_input   (sel_input),
    .sel_ref     (sel_ref),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .ref_data    (ref_data),
    .err_timeout (err_timeout),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic longint model_raw(input bundle_t b);
    return (longint'(b.p) - longint'(b.n)) * longint'(RUNUP) + longint'(b.rd) * 512
         - longint'(b.n64) * 64 + longint'(b.p8) * 8 - longint'(b.n1);
  endfunction

  function automatic logic [RW-1:0] model_diff(input bundle_t a, input bundle_t z);
    longint d;
    d = model_raw(a) - model_raw(z);
    return d[RW-1:0];
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.p   = $urandom;
    b.n   = $urandom;
    b.rd  = 12'($urandom);
    b.n64 = 8'($urandom);
    b.p8  = 8'($urandom);
    b.n1  = 8'($urandom);
    return b;
  endfunction

  function automatic bundle_t mk(input int p, input int n, input int rd, input int a, input int b, input int c);
    bundle_t r;
    r.p = 32'(p); r.n = 32'(n); r.rd = 12'(rd); r.n64 = 8'(a); r.p8 = 8'(b); r.n1 = 8'(c);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for conv_start, checks the mux selection, then answers after a random WAIT delay.
  // Returns sampled in the CALC cycle.
  task automatic run_phase(input bundle_t b, input logic [2:0] sel_exp);
    int n;
    n = 0;
    while (!conv_start && n < 200) begin tick(); n++; end
    checks++;
    if (conv_start !== 1'b1) begin
      errors++;
      $display("FAIL start_wait: conv_start=%0b after %0d cycles, required 1", conv_start, n);
    end
    checks++;
    if ({sel_zero, sel_input, sel_ref} !== sel_exp) begin
      errors++;
      $display("FAIL phase_sel: sel={%0b%0b%0b}, required %b", sel_zero, sel_input, sel_ref, sel_exp);
    end
    tick();
    repeat ($urandom_range(0, 15)) tick();
    pwm_p = b.p; pwm_n = b.n; rundown = b.rd; n64 = b.n64; p8 = b.p8; n1 = b.n1;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    pwm_p = $urandom; pwm_n = $urandom; rundown = 12'($urandom);
  endtask

  task automatic check_out(input logic [RW-1:0] e_res, input logic [RW-1:0] e_ref, input string tag);
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL %s_valid: res_valid=%0b, required 1", tag, res_valid);
    end
    checks++;
    if (res_data !== e_res) begin
      errors++; $display("FAIL %s_res_data: got %0d, required %0d", tag, $signed(res_data), $signed(e_res));
    end
    checks++;
    if (ref_data !== e_ref) begin
      errors++; $display("FAIL %s_ref_data: got %0d, required %0d", tag, $signed(ref_data), $signed(e_ref));
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({conv_start, sel_zero, sel_input, sel_ref, res_valid, err_timeout} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 000000",
        {conv_start, sel_zero, sel_input, sel_ref, res_valid, err_timeout});
    end
    checks++;
    if (res_data !== '0 || ref_data !== '0) begin
      errors++; $display("FAIL reset_data: res=%0h ref=%0h, required 0", res_data, ref_data);
    end
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
    end
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (conv_start !== 1'b0 || sel_zero !== 1'b0) begin
      errors++; $display("FAIL idle_hold: conv_start=%0b sel_zero=%0b, required 0 0", conv_start, sel_zero);
    end
  endtask

  task automatic test_known_sequence();
    bundle_t z, in, rf;
    logic [RW-1:0] e_ref;
    int n;
    z  = mk(1000, 1000, 2, 1, 3, 5);
    in = mk(1200, 1000, 2, 1, 3, 5);
    rf = mk(1000, 1200, 2, 1, 3, 5);
    enable = 1'b1;
    tick();
    checks++;
    if ({sel_zero, sel_input, sel_ref} !== 3'b100) begin
      errors++; $display("FAIL settle_entry_sel: got %b, required 100", {sel_zero, sel_input, sel_ref});
    end
    n = 0;
    while (!conv_start && n < 50) begin tick(); n++; end
    checks++;
    if (n != SETTLE) begin
      errors++; $display("FAIL settle_len: conv_start after %0d settle cycles, required %0d", n, SETTLE);
    end
    run_phase(z, 3'b100);
    run_phase(in, 3'b010);
`ifdef REF_CAL_EN
    run_phase(rf, 3'b001);
    e_ref = '0;
    e_ref = e_ref - RW'(50000);
`else
    e_ref = '0;
    checks++;
    if (model_raw(rf) == model_raw(z) || sel_ref !== 1'b0) begin
      errors++; $display("FAIL sel_ref_tied: sel_ref=%0b, required 0", sel_ref);
    end
`endif
    tick();
    check_out(RW'(50000), e_ref, "known");
  endtask

  task automatic test_hold_ready();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || conv_start !== 1'b0 || res_data !== RW'(50000)) begin
        errors++; $display("FAIL hold_%0d: valid=%0b start=%0b data=%0d, required 1 0 50000",
          i, res_valid, conv_start, $signed(res_data));
      end
    end
    accept();
    checks++;
    if (res_valid !== 1'b0 || {sel_zero, sel_input, sel_ref} !== 3'b100) begin
      errors++; $display("FAIL accept_restart: valid=%0b sel=%b, required 0 100",
        res_valid, {sel_zero, sel_input, sel_ref});
    end
  endtask

  task automatic test_back_to_back();
    bundle_t z, in, rf;
    logic [RW-1:0] e_ref;
    for (int k = 0; k < 6; k++) begin
      z = rand_bundle(); in = rand_bundle(); rf = rand_bundle();
      res_ready = (k == 0);
      run_phase(z, 3'b100);
      res_ready = 1'b0;
      run_phase(in, 3'b010);
`ifdef REF_CAL_EN
      run_phase(rf, 3'b001);
      e_ref = model_diff(rf, z);
`else
      e_ref = '0;
`endif
      tick();
      check_out(model_diff(in, z), e_ref, "b2b");
      repeat ($urandom_range(0, 3)) tick();
      accept();
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    while (!conv_start && n < 50) begin tick(); n++; end
    checks++;
    if (conv_start !== 1'b1) begin
      errors++; $display("FAIL tmo_start: conv_start=%0b, required 1", conv_start);
    end
    n = 0;
    while (!err_timeout && n < 150) begin tick(); n++; end
    checks++;
    if (n != TMO) begin
      errors++; $display("FAIL tmo_delay: err_timeout after %0d cycles, required %0d", n, TMO);
    end
    exp_err++;
    tick();
    checks++;
    if (err_cnt !== 8'(exp_err) || err_timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_cnt: err_cnt=%0d pulse=%0b, required %0d 0", err_cnt, err_timeout, exp_err);
    end
    checks++;
    if ({sel_zero, sel_input, sel_ref, res_valid} !== 4'b0) begin
      errors++; $display("FAIL tmo_idle: sel/valid=%b, required 0000", {sel_zero, sel_input, sel_ref, res_valid});
    end
    tick();
    checks++;
    if ({sel_zero, sel_input, sel_ref} !== 3'b100) begin
      errors++; $display("FAIL tmo_restart: sel=%b, required 100", {sel_zero, sel_input, sel_ref});
    end
  endtask

  task automatic test_enable_drop_wait();
    int n;
    run_phase(rand_bundle(), 3'b100);
    n = 0;
    while (!conv_start && n < 50) begin tick(); n++; end
    tick();
    enable = 1'b0;
    repeat (3) tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    tick();
    checks++;
    if ({sel_zero, sel_input, sel_ref, res_valid} !== 4'b0) begin
      errors++; $display("FAIL drop_wait_idle: sel/valid=%b, required 0000", {sel_zero, sel_input, sel_ref, res_valid});
    end
    for (int i = 0; i < 10; i++) begin
      conv_done = (i == 4);
      tick();
      checks++;
      if (conv_start !== 1'b0 || res_valid !== 1'b0) begin
        errors++; $display("FAIL drop_wait_quiet_%0d: start=%0b valid=%0b, required 0 0", i, conv_start, res_valid);
      end
    end
    conv_done = 1'b0;
  endtask

  task automatic test_enable_drop_out();
    bundle_t z, in, rf;
    logic [RW-1:0] e_ref;
    enable = 1'b1;
    z = rand_bundle(); in = rand_bundle(); rf = rand_bundle();
    run_phase(z, 3'b100);
    run_phase(in, 3'b010);
`ifdef REF_CAL_EN
    run_phase(rf, 3'b001);
    e_ref = model_diff(rf, z);
`else
    e_ref = '0;
`endif
    tick();
    enable = 1'b0;
    repeat (3) tick();
    check_out(model_diff(in, z), e_ref, "drop_out");
    accept();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({conv_start, res_valid, sel_zero} !== 3'b0) begin
        errors++; $display("FAIL drop_out_idle_%0d: start/valid/sel_zero=%b, required 000", i,
          {conv_start, res_valid, sel_zero});
      end
    end
  endtask

  task automatic test_async_reset();
    bundle_t z, in;
    int n;
    enable = 1'b1;
    n = 0;
    while (!conv_start && n < 50) begin tick(); n++; end
    tick();
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({conv_start, sel_zero, sel_input, sel_ref, res_valid, err_timeout} !== 6'b0) begin
      errors++; $display("FAIL async_rst_ctrl: got %b, required 000000",
        {conv_start, sel_zero, sel_input, sel_ref, res_valid, err_timeout});
    end
    checks++;
    if (err_cnt !== 8'd0 || res_data !== '0 || ref_data !== '0) begin
      errors++; $display("FAIL async_rst_data: err_cnt=%0d res=%0h ref=%0h, required 0 0 0", err_cnt, res_data, ref_data);
    end
    exp_err = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    z = rand_bundle(); in = rand_bundle();
    run_phase(z, 3'b100);
    run_phase(in, 3'b010);
`ifdef REF_CAL_EN
    run_phase(z, 3'b001);
`endif
    tick();
    check_out(model_diff(in, z), '0, "post_rst");
    accept();
  endtask

  initial begin
    test_reset();
    test_known_sequence();
    test_hold_ready();
    test_back_to_back();
    test_timeout();
    test_enable_drop_wait();
    test_enable_drop_out();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
